// File: rtl/regfile_scoreboard.sv
// Register file (2 async reads, 1 sync write) with write bypass, zero register and per-register pending scoreboard.
// Reads are zero-latency. Ready stays low while the post-reset sweep loads every register (DEPTH edges).
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          INIT_IDX = 1'b1
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReserveReg,
  input  logic              Reserve,
  output logic              Pending1,
  output logic              Pending2,
  output logic              Ready
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                ready_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]    pend_q;
  logic [DEPTH-1:0]    pend_d;

  logic                run;
  logic                wr_en;
  logic                rsv_en;
  logic                hit1;
  logic                hit2;
  logic                zero1;
  logic                zero2;
  logic [DATA_W-1:0]   init_val;

  assign run      = (state_q == S_RUN);
  assign wr_en    = run && RegWrite && !(ZERO_REG && (WriteReg == '0));
  assign rsv_en   = run && Reserve && !(ZERO_REG && (ReserveReg == '0));
  assign init_val = INIT_IDX ? DATA_W'(ptr_q) : '0;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == S_INIT) begin
      ptr_q <= ptr_q + 1'b1;
      if (ptr_q == ADDR_W'(DEPTH - 1)) begin
        state_q <= S_RUN;
        ready_q <= 1'b1;
      end
    end
  end

  // Storage has no reset; the INIT sweep is what gives it defined contents.
  always_ff @(posedge Clk) begin
    if (!run) begin
      mem_q[ptr_q] <= init_val;
    end else if (wr_en) begin
      mem_q[WriteReg] <= WriteData;
    end
  end

  // Reserve is applied after the writeback clear so a new producer supersedes the retiring one.
  always_comb begin
    pend_d = pend_q;
    if (wr_en) begin
      pend_d[WriteReg] = 1'b0;
    end
    if (rsv_en) begin
      pend_d[ReserveReg] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign hit1  = BYPASS && wr_en && (WriteReg == ReadReg1);
  assign hit2  = BYPASS && wr_en && (WriteReg == ReadReg2);
  assign zero1 = ZERO_REG && (ReadReg1 == '0);
  assign zero2 = ZERO_REG && (ReadReg2 == '0);

  assign ReadData1 = (!run || zero1) ? '0 : (hit1 ? WriteData : mem_q[ReadReg1]);
  assign ReadData2 = (!run || zero2) ? '0 : (hit2 ? WriteData : mem_q[ReadReg2]);
  assign Pending1  = run && !zero1 && pend_q[ReadReg1] && !hit1;
  assign Pending2  = run && !zero2 && pend_q[ReadReg2] && !hit2;
  assign Ready     = ready_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing instance and a non-bypassing twin share all inputs.
module tb_regfile_scoreboard;
  logic        Clk;
  logic        reset;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg, ReserveReg;
  logic [31:0] WriteData;
  logic        RegWrite, Reserve;
  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        p1, p2, ready, nb_p1, nb_p2, nb_ready;

  int n_err = 0;
  int n_checks = 0;

  localparam int S_RD1 = 0, S_RD2 = 1, S_P1 = 2, S_P2 = 3, S_RDY = 4,
                 S_NB_RD1 = 5, S_NB_P1 = 6, S_NB_RDY = 7, S_NB_RD2 = 8;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t exp_q[$];

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1), .INIT_IDX(1'b1)) dut (
    .Clk(Clk), .reset(reset),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1), .ReadData2(rd2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReserveReg(ReserveReg), .Reserve(Reserve),
    .Pending1(p1), .Pending2(p2), .Ready(ready)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0), .INIT_IDX(1'b1)) dut_nb (
    .Clk(Clk), .reset(reset),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(nb_rd1), .ReadData2(nb_rd2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReserveReg(ReserveReg), .Reserve(Reserve),
    .Pending1(nb_p1), .Pending2(nb_p2), .Ready(nb_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      S_RD1:    return rd1;
      S_RD2:    return rd2;
      S_P1:     return {31'd0, p1};
      S_P2:     return {31'd0, p2};
      S_RDY:    return {31'd0, ready};
      S_NB_RD1: return nb_rd1;
      S_NB_P1:  return {31'd0, nb_p1};
      S_NB_RDY: return {31'd0, nb_ready};
      S_NB_RD2: return nb_rd2;
      default:  return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] e);
    exp_q.push_back('{tag, sel, e});
  endtask

  // Let combinational outputs settle, then drain every queued expectation.
  task automatic check();
    exp_t        e;
    logic [31:0] o;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs(e.sel);
      n_checks++;
      assert (o === e.exp) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    RegWrite = 1'b0;
    Reserve  = 1'b0;
  endtask

  // Ready must be low after edges 1..31 and high after edge 32, on both instances.
  task automatic sweep(input string tag);
    for (int i = 1; i <= 32; i++) begin
      tick();
      expect_val(tag, S_RDY, {31'd0, (i == 32)});
      expect_val({tag, "_nb"}, S_NB_RDY, {31'd0, (i == 32)});
      if (i == 10) begin
        expect_val({tag, "_init_rd"}, S_RD1, 32'd0);
        expect_val({tag, "_init_pend"}, S_P1, 32'd0);
      end
      check();
    end
  endtask

  initial begin
    reset = 1'b0;
    ReadReg1 = 5'd7; ReadReg2 = 5'd31; WriteReg = '0; ReserveReg = '0;
    WriteData = '0; RegWrite = 1'b0; Reserve = 1'b0;

    expect_val("rst_ready", S_RDY, 32'd0);
    expect_val("rst_rd1", S_RD1, 32'd0);
    check();
    repeat (3) tick();
    reset = 1'b1;

    // Requests during the sweep must be ignored.
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'hFFFF_FFFF;
    Reserve = 1'b1; ReserveReg = 5'd7;
    sweep("init1");
    idle_inputs();
    expect_val("init_r7", S_RD1, 32'd7);
    expect_val("init_r31", S_RD2, 32'd31);
    expect_val("init_no_pend", S_P1, 32'd0);
    check();

    // Same-cycle write and read of R5.
    ReadReg1 = 5'd5; WriteReg = 5'd5; WriteData = 32'hDEAD_BEEF; RegWrite = 1'b1;
    expect_val("bypass_rd1", S_RD1, 32'hDEAD_BEEF);
    expect_val("nobypass_rd1", S_NB_RD1, 32'd5);
    check();
    tick(); idle_inputs();
    expect_val("after_wr_rd1", S_RD1, 32'hDEAD_BEEF);
    expect_val("nobypass_next", S_NB_RD1, 32'hDEAD_BEEF);
    check();

    // Register 0 is hardwired.
    ReadReg2 = 5'd0; WriteReg = 5'd0; WriteData = 32'h1234; RegWrite = 1'b1;
    expect_val("r0_wr_same", S_RD2, 32'd0);
    check();
    tick(); idle_inputs();
    expect_val("r0_after_wr", S_RD2, 32'd0);
    expect_val("r0_after_wr_nb", S_NB_RD2, 32'd0);
    check();
    Reserve = 1'b1; ReserveReg = 5'd0;
    tick(); idle_inputs();
    expect_val("r0_reserve", S_P2, 32'd0);
    check();

    // Reserve R9, then release by writeback.
    ReadReg1 = 5'd9; Reserve = 1'b1; ReserveReg = 5'd9;
    expect_val("r9_not_yet", S_P1, 32'd0);
    check();
    tick(); idle_inputs();
    expect_val("r9_pending", S_P1, 32'd1);
    expect_val("r9_old", S_RD1, 32'd9);
    check();
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'hAA;
    expect_val("r9_wb_release", S_P1, 32'd0);
    expect_val("r9_wb_data", S_RD1, 32'hAA);
    expect_val("r9_wb_nb_stall", S_NB_P1, 32'd1);
    expect_val("r9_wb_nb_old", S_NB_RD1, 32'd9);
    check();
    tick(); idle_inputs();
    expect_val("r9_clear", S_P1, 32'd0);
    expect_val("r9_clear_nb", S_NB_P1, 32'd0);
    expect_val("r9_data", S_RD1, 32'hAA);
    check();

    // Reserve and write R3 together: set wins.
    ReadReg2 = 5'd3; Reserve = 1'b1; ReserveReg = 5'd3;
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h55;
    expect_val("r3_same_pend", S_P2, 32'd0);
    expect_val("r3_same_rd", S_RD2, 32'h55);
    check();
    tick(); idle_inputs();
    expect_val("r3_set_wins", S_P2, 32'd1);
    expect_val("r3_data", S_RD2, 32'h55);
    check();

    // Both ports on one register; re-reserve keeps pending.
    ReadReg1 = 5'd3; Reserve = 1'b1; ReserveReg = 5'd3;
    tick(); idle_inputs();
    expect_val("dual_p1", S_P1, 32'd1);
    expect_val("dual_p2", S_P2, 32'd1);
    expect_val("dual_rd1", S_RD1, 32'h55);
    check();

    // Different registers in one cycle: both updates apply.
    ReadReg1 = 5'd10; Reserve = 1'b1; ReserveReg = 5'd10;
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h66;
    tick(); idle_inputs();
    expect_val("diff_set", S_P1, 32'd1);
    expect_val("diff_clr", S_P2, 32'd0);
    expect_val("diff_data", S_RD2, 32'h66);
    check();

    // Reset mid-sweep at ptr=12.
    reset = 1'b0;
    expect_val("rst_run_drop", S_RDY, 32'd0);
    check();
    tick();
    reset = 1'b1;
    repeat (12) tick();
    reset = 1'b0;
    expect_val("rst_mid_ready", S_RDY, 32'd0);
    check();
    tick();
    reset = 1'b1;
    sweep("init2");

    // Reset in RUN with R4 pending.
    ReadReg1 = 5'd4; Reserve = 1'b1; ReserveReg = 5'd4;
    tick(); idle_inputs();
    expect_val("r4_pending", S_P1, 32'd1);
    check();
    reset = 1'b0;
    expect_val("rst_ready_drop", S_RDY, 32'd0);
    expect_val("rst_pend_drop", S_P1, 32'd0);
    expect_val("rst_rd_zero", S_RD1, 32'd0);
    check();
    tick();
    reset = 1'b1;
    sweep("init3");
    ReadReg2 = 5'd10;
    expect_val("r4_cleared", S_P1, 32'd0);
    expect_val("r10_cleared", S_P2, 32'd0);
    expect_val("r4_reinit", S_RD1, 32'd4);
    expect_val("r10_reinit", S_RD2, 32'd10);
    check();
    ReadReg1 = 5'd5; ReadReg2 = 5'd9;
    expect_val("r5_reinit", S_RD1, 32'd5);
    expect_val("r9_reinit", S_RD2, 32'd9);
    check();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
